// File: rtl/turret_pkg.sv
// Shared types and constants for the turret aiming controller: angle map,
// per-angle motion/spawn table, per-turret key bindings and mirroring.
package turret_pkg;

    localparam int N_ANGLES    = 9;
    localparam int MAX_TURRETS = 4;

    typedef enum logic [3:0] {
        ANG_270 = 4'd0, ANG_300, ANG_315, ANG_330, ANG_0,
        ANG_30, ANG_45, ANG_60, ANG_90
    } angle_e;

    localparam logic [3:0] RESET_IDX = 4'(ANG_0);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} rpt_state_e;

    typedef struct packed {
        logic signed [3:0] mx;
        logic signed [3:0] my;
        logic [7:0]        sx;
        logic [7:0]        sy;
    } angle_row_t;

    localparam angle_row_t ANGLE_TBL [N_ANGLES] = '{
        '{ 4'sd0,  4'sd1, 8'd48, 8'd78},
        '{ 4'sd1,  4'sd2, 8'd67, 8'd75},
        '{ 4'sd1,  4'sd1, 8'd73, 8'd71},
        '{ 4'sd2,  4'sd1, 8'd73, 8'd60},
        '{ 4'sd1,  4'sd0, 8'd85, 8'd40},
        '{ 4'sd2, -4'sd1, 8'd65, 8'd25},
        '{ 4'sd1, -4'sd1, 8'd40, 8'd42},
        '{ 4'sd1, -4'sd2, 8'd40, 8'd43},
        '{ 4'sd0, -4'sd1, 8'd38, 8'd42}
    };

    // Index 0 is turret 0 (concatenation lists the highest turret first).
    localparam logic [MAX_TURRETS-1:0][7:0] KEY_UP   = {8'h60, 8'h0C, 8'h52, 8'h1A};
    localparam logic [MAX_TURRETS-1:0][7:0] KEY_DOWN = {8'h5A, 8'h0E, 8'h51, 8'h16};
    localparam logic [MAX_TURRETS-1:0][7:0] KEY_FIRE = {8'h62, 8'h0F, 8'h28, 8'h2C};
    localparam logic [MAX_TURRETS-1:0]      MIRROR   = 4'b1010;

    function automatic logic [8:0] onehot9(input logic [3:0] idx);
        return 9'd1 << idx;
    endfunction

endpackage

// File: rtl/turret_aim_ctrl_if.sv
// Keycode input, per-turret aim outputs and the shot handshake to the bullet engine.
interface turret_aim_ctrl_if #(
    parameter int NUM_TURRETS = 2,
    parameter int NUM_KEYS    = 4,
    parameter int COORD_W     = 10
);
    logic [NUM_KEYS-1:0][7:0]             keycode;
    logic [NUM_TURRETS-1:0][3:0]          angle_idx;
    logic [NUM_TURRETS-1:0][8:0]          angle_flag;
    logic [NUM_TURRETS-1:0][COORD_W-1:0]  motion_x, motion_y, spawn_x, spawn_y;
    logic [NUM_TURRETS-1:0]               fire_valid, fire_ready;
    logic [NUM_TURRETS-1:0][COORD_W-1:0]  fire_motion_x, fire_motion_y;
    logic [NUM_TURRETS-1:0][COORD_W-1:0]  fire_spawn_x, fire_spawn_y;

    modport master (
        output keycode, fire_ready,
        input  angle_idx, angle_flag, motion_x, motion_y, spawn_x, spawn_y,
               fire_valid, fire_motion_x, fire_motion_y, fire_spawn_x, fire_spawn_y
    );

    modport slave (
        input  keycode, fire_ready,
        output angle_idx, angle_flag, motion_x, motion_y, spawn_x, spawn_y,
               fire_valid, fire_motion_x, fire_motion_y, fire_spawn_x, fire_spawn_y
    );
endinterface

// File: rtl/turret_angle_rom.sv
// Combinational angle index -> motion/spawn row, optionally mirrored about the
// vertical screen axis for turrets on the right-hand side.
module turret_angle_rom
    import turret_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int SCREEN_W  = 640,
    parameter bit MIRROR_EN = 1'b0
) (
    input  logic [3:0]         i_idx,
    output logic [COORD_W-1:0] o_mx,
    output logic [COORD_W-1:0] o_my,
    output logic [COORD_W-1:0] o_sx,
    output logic [COORD_W-1:0] o_sy
);
    angle_row_t         w_row;
    logic [COORD_W-1:0] w_mx, w_sx;

    always_comb begin
        w_row = ANGLE_TBL[RESET_IDX];
        if (i_idx < 4'(N_ANGLES))
            w_row = ANGLE_TBL[i_idx];
    end

    assign w_mx = {{(COORD_W-4){w_row.mx[3]}}, w_row.mx};
    assign o_my = {{(COORD_W-4){w_row.my[3]}}, w_row.my};
    assign w_sx = {{(COORD_W-8){1'b0}}, w_row.sx};
    assign o_sy = {{(COORD_W-8){1'b0}}, w_row.sy};

    generate
        if (MIRROR_EN) begin : g_mirror
            assign o_mx = -w_mx;
            assign o_sx = COORD_W'(SCREEN_W - 1) - w_sx;
        end else begin : g_direct
            assign o_mx = w_mx;
            assign o_sx = w_sx;
        end
    endgenerate
endmodule

// File: rtl/turret_aim_ctrl.sv
// Multi-turret aim/fire controller: keycode decode, step edge detect, angle
// register and shot latch per turret. Auto-repeat built when TURRET_AUTOREPEAT_EN is defined.
module turret_aim_ctrl
    import turret_pkg::*;
#(
    parameter int NUM_TURRETS   = 2,
    parameter int NUM_KEYS      = 4,
    parameter int COORD_W       = 10,
    parameter int SCREEN_W      = 640,
    parameter int REPEAT_DELAY  = 24,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    turret_aim_ctrl_if.slave bus
);

    for (genvar t = 0; t < NUM_TURRETS; t++) begin : g_tur
        logic               w_up, w_dn, w_fire;
        logic               w_up_only, w_dn_only, w_press, w_step;
        logic               r_up_q, r_dn_q, r_fire_q;
        logic [3:0]         r_idx;
        logic [COORD_W-1:0] w_mx, w_my, w_sx, w_sy;
        logic               r_fv;
        logic [COORD_W-1:0] r_fmx, r_fmy, r_fsx, r_fsy;

        always_comb begin
            w_up   = 1'b0;
            w_dn   = 1'b0;
            w_fire = 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                w_up   = w_up   | (bus.keycode[k] == KEY_UP[t]);
                w_dn   = w_dn   | (bus.keycode[k] == KEY_DOWN[t]);
                w_fire = w_fire | (bus.keycode[k] == KEY_FIRE[t]);
            end
        end

        // Opposing keys cancel; a key only "presses" when it newly appears alone.
        assign w_up_only = w_up & ~w_dn;
        assign w_dn_only = w_dn & ~w_up;
        assign w_press   = (w_up_only & ~r_up_q) | (w_dn_only & ~r_dn_q);

`ifdef TURRET_AUTOREPEAT_EN
        localparam int CNT_W = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ?
                                      REPEAT_DELAY : REPEAT_PERIOD) + 1;
        rpt_state_e       r_state, w_state_nxt;
        logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
        logic             w_rpt;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rpt       = 1'b0;
            if (!(w_up_only | w_dn_only)) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else if (w_press) begin
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (r_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                            w_rpt       = 1'b1;
                            w_state_nxt = S_REPEAT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (r_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                            w_rpt     = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign w_step = w_press | w_rpt;
`else
        assign w_step = w_press;
`endif

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                r_up_q   <= 1'b0;
                r_dn_q   <= 1'b0;
                r_fire_q <= 1'b0;
                r_idx    <= RESET_IDX;
            end else begin
                r_up_q   <= w_up;
                r_dn_q   <= w_dn;
                r_fire_q <= w_fire;
                if (w_step && w_up_only && r_idx != 4'(N_ANGLES - 1))
                    r_idx <= r_idx + 1'b1;
                else if (w_step && w_dn_only && r_idx != 4'd0)
                    r_idx <= r_idx - 1'b1;
            end
        end

        turret_angle_rom #(
            .COORD_W  (COORD_W),
            .SCREEN_W (SCREEN_W),
            .MIRROR_EN(MIRROR[t])
        ) u_rom (
            .i_idx(r_idx),
            .o_mx (w_mx),
            .o_my (w_my),
            .o_sx (w_sx),
            .o_sy (w_sy)
        );

        // Snapshot is taken from the registered angle, so a same-edge step is not seen.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                r_fv  <= 1'b0;
                r_fmx <= '0;
                r_fmy <= '0;
                r_fsx <= '0;
                r_fsy <= '0;
            end else if (r_fv) begin
                if (bus.fire_ready[t])
                    r_fv <= 1'b0;
            end else if (w_fire && !r_fire_q) begin
                r_fv  <= 1'b1;
                r_fmx <= w_mx;
                r_fmy <= w_my;
                r_fsx <= w_sx;
                r_fsy <= w_sy;
            end
        end

        assign bus.angle_idx[t]     = r_idx;
        assign bus.angle_flag[t]    = onehot9(r_idx);
        assign bus.motion_x[t]      = w_mx;
        assign bus.motion_y[t]      = w_my;
        assign bus.spawn_x[t]       = w_sx;
        assign bus.spawn_y[t]       = w_sy;
        assign bus.fire_valid[t]    = r_fv;
        assign bus.fire_motion_x[t] = r_fmx;
        assign bus.fire_motion_y[t] = r_fmy;
        assign bus.fire_spawn_x[t]  = r_fsx;
        assign bus.fire_spawn_y[t]  = r_fsy;
    end

endmodule

// File: doc/turret_aim_ctrl.md
# turret_aim_ctrl

Multi-turret aiming and firing controller. Decodes keyboard keycodes into per-turret angle steps across nine fixed firing angles (270° through 90°), with edge detection and optional auto-repeat. Drives one-hot angle flags, bullet motion vectors and spawn offsets to the sprite and bullet logic. Hands each shot to the bullet engine over a valid/ready handshake. Sits between the USB keycode interface and the bullet/turret sprite modules, clocked by the frame-logic clock.

## Interface
Parameters:
- NUM_TURRETS, 2, independent turrets (1..4)
- NUM_KEYS, 4, simultaneous keycode slots scanned per cycle
- COORD_W, 10, width of motion and spawn outputs
- SCREEN_W, 640, used for mirrored spawn x
- REPEAT_DELAY, 24, cycles a step key is held before auto-repeat starts
- REPEAT_PERIOD, 8, cycles between auto-repeat steps

Ports (all per-turret outputs are arrays indexed [NUM_TURRETS]):
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- keycode  in  NUM_KEYS×8  current pressed keycodes; 8'h00 = empty slot
- angle_idx  out  4  current angle index 0..8
- angle_flag  out  9  one-hot of angle_idx
- motion_x, motion_y  out  COORD_W  two's-complement bullet step per frame
- spawn_x, spawn_y  out  COORD_W  bullet spawn offset from turret origin
- fire_valid  out  1  shot pending
- fire_motion_x/y, fire_spawn_x/y  out  COORD_W  shot snapshot, stable while fire_valid
- fire_ready  in  1  bullet engine accepts shot

## Operation
- Angle index map: 0=270°, 1=300°, 2=315°, 3=330°, 4=0°, 5=30°, 6=45°, 7=60°, 8=90°.
- Table (mx,my,sx,sy): 270:(0,1,48,78); 300:(1,2,67,75); 315:(1,1,73,71); 330:(2,1,73,60); 0:(1,0,85,40); 30:(2,-1,65,25); 45:(1,-1,40,42); 60:(1,-2,40,43); 90:(0,-1,38,42).
- Turret i keys come from package arrays KEY_UP[i], KEY_DOWN[i], KEY_FIRE[i]. Turret 0 defaults: 8'h1A, 8'h16, 8'h2C. A key counts as held when it matches any keycode slot.
- Up step: idx+1, saturating at 8. Down step: idx-1, saturating at 0. No wrap.
- Up and down held together: no step; the repeat FSM returns to IDLE.
- Per-turret repeat FSM:
  - IDLE: on a press edge (held now, not held last cycle) -> step, then HOLD.
  - HOLD: counts REPEAT_DELAY cycles, then steps -> REPEAT.
  - REPEAT: steps every REPEAT_PERIOD cycles.
  - Release from any state -> IDLE.
- Mirroring: turrets with package constant MIRROR[i]=1 output motion_x negated and spawn_x = SCREEN_W-1-sx.
- Fire:
  - A fire press edge with fire_valid=0 latches the current table row (after mirroring) into the fire_* outputs and sets fire_valid.
  - fire_valid falls on the cycle after fire_valid&&fire_ready.
  - Fire edges while pending are dropped.
  - Angle changes while pending do not alter the snapshot.
- Reset values: angle_idx=4, angle_flag=9'h010, motion=(1,0), spawn=(85,40) (mirrored where MIRROR[i] is set), fire_valid=0, fire_* = 0, all FSMs IDLE, key history cleared.

## Timing
- Key held state: combinational from keycode. Previous-state register updates every Clk.
- A step is registered at the edge where the press is detected. angle_idx, angle_flag, motion and spawn change 1 cycle after keycode first shows the key.
- Table outputs are combinational from the angle register: no added latency.
- Auto-repeat: the first repeat step lands REPEAT_DELAY cycles after the initial step, then one step every REPEAT_PERIOD cycles.
- fire_valid rises 1 cycle after the fire key appears.
- Fire and step on the same edge: the snapshot uses the pre-step angle.
- Reset asserted mid-repeat or mid-handshake clears state immediately. The pending shot is lost.

## Configuration
- TURRET_AUTOREPEAT_EN defined: HOLD/REPEAT states and counters are built as above.
- Not defined: FSM is IDLE-only. Exactly one step per press edge. Counters are not instantiated.

## Structure
- Package turret_pkg: angle enum, angle table row struct and 9-entry table constant, KEY_UP/KEY_DOWN/KEY_FIRE and MIRROR arrays, reset index constant (4).
- Sub-module turret_angle_rom: combinational index → row with mirror option. Instantiated once per turret for the live outputs.
- Top module generates NUM_TURRETS channels of edge detect, repeat FSM, angle register and fire latch.

## Test plan
- After reset, turret 0 = idx 4, flag 9'h010, motion (1,0), spawn (85,40), fire_valid=0.
- keycode slot0=8'h1A for 1 cycle, then released → idx 5, motion (2,-1), spawn (65,25). Apply 5 more presses → saturates at idx 8, motion (0,-1).
- Hold 8'h16 for 60 cycles with TURRET_AUTOREPEAT_EN, REPEAT_DELAY=24, REPEAT_PERIOD=8 → steps at cycles 1, 25, 33, 41, 49, 57. idx 4 reaches 0 at cycle 41 and stays there. Without the macro → exactly 1 step.
- 8'h1A in slot0 and 8'h16 in slot2 at the same time → no change.
- Fire at idx 4 with fire_ready=0 → fire_valid=1, snapshot (1,0,85,40). Then step to idx 5 → snapshot unchanged. Raise fire_ready → fire_valid falls the next cycle.
- Mirrored turret 1 at reset → motion_x = -1 (10'h3FF), spawn_x = 554. Reset asserted during a pending shot → fire_valid=0 immediately.
